// File: rtl/hue_cycle_pwm_if.sv
// Control/status bundle for hue_cycle_pwm: run request in, PWM pins and
// hue position out.
interface hue_cycle_pwm_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned STEPS  = 100
);
    localparam int unsigned SegW  = $clog2(2 * NUM_CH);
    localparam int unsigned RampW = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic              run;
    logic [NUM_CH-1:0] pwm_out;
    logic [SegW-1:0]   segment;
    logic [RampW-1:0]  ramp;
    logic              wrap;

    modport master (output run, input pwm_out, input segment, input ramp, input wrap);
    modport slave  (input run, output pwm_out, output segment, output ramp, output wrap);
endinterface

// File: rtl/hue_cycle_pwm.sv
// Colour-wheel PWM engine: NUM_CH channels follow phase-shifted trapezoid duties.
// Define PWM_ACTIVE_LOW_EN for inverted (current-sink) pwm_out polarity.
module hue_cycle_pwm #(
    parameter int unsigned NUM_CH       = 3,
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned STEPS        = 100,
    parameter int unsigned STEP_PERIODS = 20
) (
    input logic            clk,
    input logic            reset,
    hue_cycle_pwm_if.slave bus
);
    localparam int unsigned NumSeg   = 2 * NUM_CH;
    localparam int unsigned DutyStep = PWM_INTERVAL / STEPS;
    localparam int unsigned SegW     = $clog2(NumSeg);
    localparam int unsigned RampW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned CntW     = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    localparam int unsigned HoldW    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int unsigned DutyW    = $clog2(PWM_INTERVAL + 1);

`ifdef PWM_ACTIVE_LOW_EN
    localparam logic Inactive = 1'b1;
`else
    localparam logic Inactive = 1'b0;
`endif

    if (NUM_CH < 2) begin : g_bad_num_ch
        $fatal(1, "hue_cycle_pwm: NUM_CH must be >= 2");
    end
    if (STEPS < 1 || PWM_INTERVAL < 1 || STEP_PERIODS < 1) begin : g_bad_zero
        $fatal(1, "hue_cycle_pwm: PWM_INTERVAL, STEPS, STEP_PERIODS must be >= 1");
    end
    if (STEPS >= 1 && (PWM_INTERVAL % STEPS) != 0) begin : g_bad_steps
        $fatal(1, "hue_cycle_pwm: PWM_INTERVAL must be a multiple of STEPS");
    end

    logic [CntW-1:0]               pwm_cnt_q;
    logic [HoldW-1:0]              hold_cnt_q;
    logic [RampW-1:0]              ramp_q;
    logic [SegW-1:0]               segment_q;
    logic [NUM_CH-1:0][DutyW-1:0]  duty_q;
    logic [NUM_CH-1:0][DutyW-1:0]  duty_d;
    logic [NUM_CH-1:0]             pwm_cmp;
    logic [NUM_CH-1:0]             pwm_q;
    logic                          wrap_q;
    logic                          period_end;
    logic [DutyW-1:0]              ramp_duty;

    assign period_end = bus.run && (pwm_cnt_q == CntW'(PWM_INTERVAL - 1));
    assign ramp_duty  = DutyW'(ramp_q) * DutyW'(DutyStep);

    // Channel c peaks around segment 2c; levels come from the pre-update position.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int unsigned K       = (2 * c) % NumSeg;
        localparam int unsigned SegRise = (K + NumSeg - 2) % NumSeg;
        localparam int unsigned SegPre  = (K + NumSeg - 1) % NumSeg;
        localparam int unsigned SegFall = (K + 1) % NumSeg;

        always_comb begin
            duty_d[c] = '0;
            if (segment_q == SegW'(SegRise)) begin
                duty_d[c] = ramp_duty;
            end else if (segment_q == SegW'(SegPre) || segment_q == SegW'(K)) begin
                duty_d[c] = DutyW'(PWM_INTERVAL);
            end else if (segment_q == SegW'(SegFall)) begin
                duty_d[c] = DutyW'(PWM_INTERVAL) - ramp_duty;
            end
        end

        assign pwm_cmp[c] = (DutyW'(pwm_cnt_q) < duty_q[c]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q  <= '0;
            hold_cnt_q <= '0;
            ramp_q     <= '0;
            segment_q  <= '0;
            duty_q     <= '0;
            pwm_q      <= {NUM_CH{Inactive}};
            wrap_q     <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            pwm_q  <= {NUM_CH{Inactive}};
            if (bus.run) begin
                pwm_q     <= pwm_cmp ^ {NUM_CH{Inactive}};
                pwm_cnt_q <= period_end ? '0 : pwm_cnt_q + CntW'(1);
            end
            if (period_end) begin
                duty_q <= duty_d;
                if (hold_cnt_q == HoldW'(STEP_PERIODS - 1)) begin
                    hold_cnt_q <= '0;
                    if (ramp_q == RampW'(STEPS - 1)) begin
                        ramp_q <= '0;
                        if (segment_q == SegW'(NumSeg - 1)) begin
                            segment_q <= '0;
                            wrap_q    <= 1'b1;
                        end else begin
                            segment_q <= segment_q + SegW'(1);
                        end
                    end else begin
                        ramp_q <= ramp_q + RampW'(1);
                    end
                end else begin
                    hold_cnt_q <= hold_cnt_q + HoldW'(1);
                end
            end
        end
    end

    assign bus.pwm_out = pwm_q;
    assign bus.segment = segment_q;
    assign bus.ramp    = ramp_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: doc/hue_cycle_pwm.md
# hue_cycle_pwm

Parametrised colour-wheel PWM engine driving N LED channels (default 3: R, G, B) from one clock. Each channel gets a glitch-free PWM waveform whose duty follows a phase-shifted trapezoid. Together the channels sweep a continuous hue cycle with configurable resolution, speed and channel count. It replaces the fixed 3-channel RGB cycler in `top` and is instantiated directly by it, with outputs wired to the LED pins.

## Interface

Parameters:
- `NUM_CH`, 3: channel count; must be ≥ 2. Hue cycle has 2·NUM_CH segments.
- `PWM_INTERVAL`, 1200: clocks per PWM period.
- `STEPS`, 100: ramp steps per segment; `PWM_INTERVAL % STEPS == 0` is required. `DUTY_STEP = PWM_INTERVAL/STEPS`.
- `STEP_PERIODS`, 20: PWM periods per ramp step.
- Any parameter violation is a fatal elaboration error.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `run` in 1: 1 = advance, 0 = pause and blank.
- `pwm_out` out NUM_CH: per-channel PWM; bit 0 = R, 1 = G, 2 = B for the default configuration.
- `segment` out $clog2(2·NUM_CH): current hue segment.
- `ramp` out $clog2(STEPS): current ramp step within the segment.
- `wrap` out 1: one-cycle pulse on full-cycle completion.

## Operation

- Registers:
  - `pwm_cnt` counts 0..PWM_INTERVAL-1.
  - `hold_cnt` counts 0..STEP_PERIODS-1.
  - `ramp` counts 0..STEPS-1.
  - `segment` counts 0..2·NUM_CH-1.
  - `duty[c]` holds a clock count per channel.
- `period_end` = `run` && `pwm_cnt == PWM_INTERVAL-1`.
- Each `run` cycle, `pwm_cnt` increments and wraps to 0 after PWM_INTERVAL-1.
- At `period_end`:
  - `hold_cnt` increments.
  - On `hold_cnt` terminal, it clears and `ramp` increments.
  - On `ramp` terminal, `ramp` clears and `segment` increments, wrapping 2·NUM_CH-1 → 0.
- Channel level L[c] is computed from the pre-update `segment` s and `ramp` r, with k = 2c mod 2N and N = NUM_CH:
  - Rising: s == (k-2) mod 2N, L = r.
  - Max: s == (k-1) mod 2N or s == k, L = STEPS.
  - Falling: s == (k+1) mod 2N, L = STEPS−r.
  - All other segments: L = 0.
- `duty[c]` loads L[c]·DUTY_STEP only at `period_end`. Duty therefore never changes mid-period, so there are no glitches.
- Output compare: `pwm_out[c] <= (pwm_cnt < duty[c])`.
  - duty 0 gives a constant inactive output.
  - duty PWM_INTERVAL gives a constant active output.
- `wrap` is 1 for exactly the cycle after `segment` wraps 2·NUM_CH-1 → 0.
- `run` = 0:
  - All counters and `duty` freeze.
  - `pwm_out` goes inactive on the next edge.
  - `wrap` = 0.
  - When `run` rises again, counting resumes from the frozen `pwm_cnt`.
- `reset` has priority over `run`. Reset values: all counters 0, all `duty` 0, `pwm_out` inactive, `wrap` 0.

## Timing

- `pwm_out` is registered, with 1-cycle latency from `pwm_cnt`/`duty` to the pin.
- A new duty takes effect at the first `pwm_cnt = 0` after `period_end`, i.e. on `pwm_out` 2 edges after `period_end`.
- After reset release with `run` = 1, the first PWM period is all-inactive because duty is 0. Channel levels first appear in period 2.
- Segment length = PWM_INTERVAL·STEP_PERIODS·STEPS clocks. Full cycle = 2·NUM_CH times that, i.e. 14.4 M clocks (1.2 s at 12 MHz) for the defaults.
- A `reset` asserted mid-segment takes effect on the next edge regardless of any pending `period_end`.

## Configuration

- `PWM_ACTIVE_LOW_EN`:
  - Defined: `pwm_out` polarity is inverted (active = 0), for iCE40 current-sink RGB pins. Reset and paused value is all-ones.
  - Undefined: active-high, with reset and paused value all-zeros.
  - No other behaviour changes.

## Test plan

Bench parameters: NUM_CH=3, PWM_INTERVAL=12, STEPS=4, STEP_PERIODS=2. This gives DUTY_STEP=3, a segment of 96 clocks and a full cycle of 576 clocks.

- Reset, then `run` = 1 → `pwm_out` = 000 for the first 13 edges. From period 2 onward R is constant 1 and B constant 0.
- Segment 0 → G high for 0, 3, 6, 9 clocks per period at ramp 0..3, each level for 2 periods. `segment` = 1 after clock 96; in segment 1, R high for 12, 9, 6, 3 clocks.
- Free-run 1200 clocks → `wrap` pulses exactly twice, one cycle each, 576 clocks apart. `segment` reads 0 in the cycle after each pulse.
- `run` = 0 at `pwm_cnt` = 5 for 20 cycles → `pwm_out` = 000 from the next edge; `pwm_cnt`, `ramp`, `segment` unchanged. After re-assert, `pwm_cnt` resumes at 5 and segment timing shifts by exactly 20 clocks.
- Assert `reset` during segment 3, ramp 2 → next edge gives `pwm_out` = 000, `segment` = 0, `ramp` = 0, `wrap` = 0. Behaviour then matches the first scenario.
- With `PWM_ACTIVE_LOW_EN` defined, rerun the first scenario → `pwm_out` = 111 during reset and period 1; R constant 0 from period 2.
